// File: rtl/tnoc_axi_read_arbiter.sv
`default_nettype none
// tnoc_axi_read_arbiter: round-robin AR arbiter sharing one AXI read port among REQUESTERS masters, with R routed back by ARID prefix.
// Optional macro TNOC_AXI_READ_ARBITER_AR_SLICE_EN adds a one-entry register slice on the m_ar* outputs.
module tnoc_axi_read_arbiter #(
   parameter  int REQUESTERS      = 2,
   parameter  int ID_WIDTH        = 4,
   parameter  int ADDR_WIDTH      = 64,
   parameter  int DATA_WIDTH      = 256,
   parameter  int MAX_OUTSTANDING = 4,
   localparam int SEL_W           = $clog2(REQUESTERS),
   localparam int PAY_W           = ADDR_WIDTH + 13,
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [REQUESTERS-1:0]          s_arvalid,
   output logic [REQUESTERS-1:0]          s_arready,
   input  logic [REQUESTERS*ID_WIDTH-1:0] s_arid,
   input  logic [REQUESTERS*PAY_W-1:0]    s_arpay,
   output logic                           m_arvalid,
   input  logic                           m_arready,
   output logic [SEL_W+ID_WIDTH-1:0]      m_arid,
   output logic [PAY_W-1:0]               m_arpay,
   input  logic                           m_rvalid,
   output logic                           m_rready,
   input  logic [SEL_W+ID_WIDTH-1:0]      m_rid,
   input  logic [DATA_WIDTH-1:0]          m_rdata,
   input  logic [1:0]                     m_rresp,
   input  logic                           m_rlast,
   output logic [REQUESTERS-1:0]          s_rvalid,
   input  logic [REQUESTERS-1:0]          s_rready,
   output logic [ID_WIDTH-1:0]            s_rid,
   output logic [DATA_WIDTH-1:0]          s_rdata,
   output logic [1:0]                     s_rresp,
   output logic                           s_rlast
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic [0:0] {IDLE = 1'b0, GRANTED = 1'b1} state_t;

   state_t                state;
   logic [SEL_W-1:0]      grant;
   logic [SEL_W-1:0]      rr;
   logic [SEL_W-1:0]      pick;
   logic [SEL_W-1:0]      rr_after;
   logic                  pick_found;
   logic                  take_ready;
   logic                  s_hs;
   logic [CNT_W-1:0]      cnt       [REQUESTERS];
   logic [ID_WIDTH-1:0]   arid_arr  [REQUESTERS];
   logic [PAY_W-1:0]      arpay_arr [REQUESTERS];
   logic [REQUESTERS-1:0] eligible;
   logic [SEL_W-1:0]      idx;
   logic                  idx_ok;
   logic                  r_last_hs;

   generate
      for (genvar i = 0; i < REQUESTERS; i++) begin : g_req
         assign arid_arr[i]  = s_arid[i*ID_WIDTH +: ID_WIDTH];
         assign arpay_arr[i] = s_arpay[i*PAY_W +: PAY_W];
         assign eligible[i]  = s_arvalid[i] && (cnt[i] < CNT_MAX);
         assign s_arready[i] = (state == GRANTED) && (grant == SEL_W'(i)) && take_ready;
         assign s_rvalid[i]  = m_rvalid && idx_ok && (idx == SEL_W'(i));

         // Simultaneous accept and last-beat return cancel out.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt[i] <= '0;
            end else begin
               if (s_hs && (grant == SEL_W'(i)) && !(r_last_hs && idx_ok && (idx == SEL_W'(i)))) begin
                  cnt[i] <= cnt[i] + 1'b1;
               end else if (!(s_hs && (grant == SEL_W'(i))) && r_last_hs && idx_ok &&
                            (idx == SEL_W'(i)) && (cnt[i] != '0)) begin
                  cnt[i] <= cnt[i] - 1'b1;
               end
            end
         end
      end
   endgenerate

   // First eligible requester at or after the round-robin pointer.
   always_comb begin : p_pick
      int j;
      j          = 0;
      pick_found = 1'b0;
      pick       = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         j = int'(rr) + k;
         if (j >= REQUESTERS) j = j - REQUESTERS;
         if (!pick_found && eligible[j]) begin
            pick_found = 1'b1;
            pick       = SEL_W'(j);
         end
      end
   end

   assign rr_after = (int'(grant) == REQUESTERS - 1) ? '0 : grant + 1'b1;

`ifdef TNOC_AXI_READ_ARBITER_AR_SLICE_EN
   logic                      sl_valid;
   logic [SEL_W+ID_WIDTH-1:0] sl_id;
   logic [PAY_W-1:0]          sl_pay;

   assign take_ready = !sl_valid || m_arready;
   assign s_hs       = (state == GRANTED) && take_ready && s_arvalid[grant];
   assign m_arvalid  = sl_valid;
   assign m_arid     = sl_id;
   assign m_arpay    = sl_pay;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sl_valid <= 1'b0;
         sl_id    <= '0;
         sl_pay   <= '0;
      end else if (s_hs) begin
         sl_valid <= 1'b1;
         sl_id    <= {grant, arid_arr[grant]};
         sl_pay   <= arpay_arr[grant];
      end else if (m_arready) begin
         sl_valid <= 1'b0;
      end
   end
`else
   assign take_ready = m_arready;
   assign s_hs       = (state == GRANTED) && m_arready;
   assign m_arvalid  = (state == GRANTED);
   assign m_arid     = {grant, arid_arr[grant]};
   assign m_arpay    = arpay_arr[grant];
`endif

   // Grant is only re-evaluated from IDLE, so it is stable while m_arvalid is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         rr    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant <= pick;
                  state <= GRANTED;
               end
            end
            GRANTED: begin
               if (s_hs) begin
                  rr    <= rr_after;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Out-of-range index beats are sunk so the adapter never stalls on them.
   assign idx       = m_rid[SEL_W+ID_WIDTH-1 -: SEL_W];
   assign idx_ok    = int'(idx) < REQUESTERS;
   assign m_rready  = idx_ok ? s_rready[idx] : 1'b1;
   assign r_last_hs = m_rvalid && m_rready && m_rlast;
   assign s_rid     = m_rid[ID_WIDTH-1:0];
   assign s_rdata   = m_rdata;
   assign s_rresp   = m_rresp;
   assign s_rlast   = m_rlast;

`ifndef SYNTHESIS
   a_no_underflow : assert property (@(posedge clk) disable iff (rst)
      (r_last_hs && idx_ok) |-> (cnt[idx] != '0));
   a_idx_range : assert property (@(posedge clk) disable iff (rst)
      m_rvalid |-> idx_ok);
`endif

endmodule
`default_nettype wire

// File: tb/tb_tnoc_axi_read_arbiter.sv
`default_nettype none
// tb_tnoc_axi_read_arbiter: randomized masters and adapter against a request-level arbitration/routing model.
module tb_tnoc_axi_read_arbiter;
   localparam int N     = 2;
   localparam int IDW   = 4;
   localparam int AW    = 64;
   localparam int DW    = 256;
   localparam int MO    = 4;
   localparam int SELW  = 1;
   localparam int PW    = AW + 13;
   localparam int MIDW  = SELW + IDW;

   logic               clk = 1'b0;
   logic               rst;
   logic [N-1:0]       s_arvalid;
   logic [N-1:0]       s_arready;
   logic [N*IDW-1:0]   s_arid;
   logic [N*PW-1:0]    s_arpay;
   logic               m_arvalid;
   logic               m_arready;
   logic [MIDW-1:0]    m_arid;
   logic [PW-1:0]      m_arpay;
   logic               m_rvalid;
   logic               m_rready;
   logic [MIDW-1:0]    m_rid;
   logic [DW-1:0]      m_rdata;
   logic [1:0]         m_rresp;
   logic               m_rlast;
   logic [N-1:0]       s_rvalid;
   logic [N-1:0]       s_rready;
   logic [IDW-1:0]     s_rid;
   logic [DW-1:0]      s_rdata;
   logic [1:0]         s_rresp;
   logic               s_rlast;

   always #5 clk = ~clk;

   tnoc_axi_read_arbiter #(
      .REQUESTERS(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst(rst),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_arpay(s_arpay),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_arpay(m_arpay),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
      .m_rresp(m_rresp), .m_rlast(m_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
      .s_rresp(s_rresp), .s_rlast(s_rlast)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference state: outstanding bursts per requester, rr pointer, pending AR decision.
   int              outstanding [N];
   int              rr_m;
   bit              busy_m;
   int              g_m;
   bit              pend  [N];
   logic [IDW-1:0]  id_q  [N];
   logic [PW-1:0]   pay_q [N];
   logic [MIDW-1:0] bq_id    [$];
   int              bq_beats [$];
   bit              r_hold;
   int              p_req, p_arr, p_rv, p_rr;
   int              grants [N];

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         outstanding[i] = 0;
         pend[i]        = 1'b0;
         id_q[i]        = '0;
         pay_q[i]       = '0;
      end
      rr_m   = 0;
      busy_m = 1'b0;
      g_m    = 0;
      r_hold = 1'b0;
      bq_id.delete();
      bq_beats.delete();
   endtask

   task automatic drive_idle();
      s_arvalid = '0; s_arid = '0; s_arpay = '0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0;
      m_rresp = '0; m_rlast = 1'b0; s_rready = '0;
   endtask

   task automatic cycle();
      int   idx;
      bit   ar_hs, r_hs, found;
      int   pick;
      logic [N-1:0] exp_ar;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && ($urandom_range(99) < p_req)) begin
            pend[i]  = 1'b1;
            id_q[i]  = IDW'($urandom);
            pay_q[i] = {{$urandom, $urandom}, 8'($urandom_range(3)), 3'($urandom), 2'($urandom)};
         end
         s_arvalid[i]             = pend[i];
         s_arid[i*IDW +: IDW]     = id_q[i];
         s_arpay[i*PW +: PW]      = pay_q[i];
         s_rready[i]              = ($urandom_range(99) < p_rr);
      end
      m_arready = ($urandom_range(99) < p_arr);
      if (!r_hold) begin
         if (bq_id.size() > 0 && ($urandom_range(99) < p_rv)) begin
            m_rvalid = 1'b1;
            m_rid    = bq_id[0];
            m_rlast  = (bq_beats[0] == 1);
            m_rdata  = {8{$urandom}};
            m_rresp  = 2'($urandom);
         end else begin
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
         end
      end
      #1;
      check("m_arvalid", m_arvalid, busy_m);
      if (busy_m) begin
         check("m_arid", m_arid, {g_m[SELW-1:0], id_q[g_m]});
         check("m_arpay", m_arpay, pay_q[g_m]);
      end
      exp_ar = '0;
      if (busy_m && m_arready) exp_ar[g_m] = 1'b1;
      check("s_arready", s_arready, exp_ar);
      idx = int'(m_rid[MIDW-1]);
      check("s_rvalid", s_rvalid, m_rvalid ? (N'(1) << idx) : N'(0));
      check("m_rready", m_rready, s_rready[idx]);
      if (m_rvalid) begin
         check("s_rid", s_rid, m_rid[IDW-1:0]);
         check("s_rdata", s_rdata, m_rdata);
         check("s_rlast", {s_rresp, s_rlast}, {m_rresp, m_rlast});
      end
      // Outcome of the upcoming clock edge, by the arbitration rules.
      ar_hs = busy_m && m_arready;
      r_hs  = m_rvalid && s_rready[idx];
      if (!busy_m) begin
         found = 1'b0; pick = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && pend[(rr_m + k) % N] && outstanding[(rr_m + k) % N] < MO) begin
               found = 1'b1;
               pick  = (rr_m + k) % N;
            end
         end
         if (found) begin
            busy_m = 1'b1;
            g_m    = pick;
         end
      end else if (ar_hs) begin
         outstanding[g_m]++;
         grants[g_m]++;
         rr_m      = (g_m + 1) % N;
         busy_m    = 1'b0;
         pend[g_m] = 1'b0;
         bq_id.push_back({g_m[SELW-1:0], id_q[g_m]});
         bq_beats.push_back(int'(pay_q[g_m][12:5]) + 1);
      end
      if (r_hs) begin
         bq_beats[0] = bq_beats[0] - 1;
         if (m_rlast) begin
            outstanding[idx]--;
            void'(bq_id.pop_front());
            void'(bq_beats.pop_front());
         end
      end
      r_hold = m_rvalid && !r_hs;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      drive_idle();
      model_reset();
      p_req = 0; p_arr = 0; p_rv = 0; p_rr = 0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_m_arvalid", m_arvalid, 1'b0);
      check("rst_s_arready", s_arready, '0);
      @(negedge clk);
      rst = 1'b0;

      // Lone request from requester 0: presented one cycle later with the index prefixed.
      pend[0]  = 1'b1;
      id_q[0]  = 4'd3;
      pay_q[0] = {64'h1000, 8'd0, 3'd5, 2'd1};
      p_arr = 100; p_rv = 0;
      cycle();
      check("t1_idle_first", m_arvalid, 1'b0);
      cycle();
      check("t1_arid", m_arid, 5'h03);
      check("t1_addr", m_arpay[PW-1:13], 64'h1000);
      repeat (2) cycle();

      // No responses: both requesters fill up to the outstanding limit and get masked.
      p_req = 100; p_arr = 70; p_rv = 0; p_rr = 100;
      repeat (40) cycle();
      check("limit0", outstanding[0], MO);
      check("limit1", outstanding[1], MO);
      check("blocked", m_arvalid, 1'b0);

      // Random traffic with responses flowing.
      p_req = 60; p_arr = 70; p_rv = 80; p_rr = 70;
      repeat (1500) cycle();

      // Saturated contention: grants must alternate.
      grants[0] = 0; grants[1] = 0;
      p_req = 100; p_arr = 100; p_rv = 100; p_rr = 100;
      repeat (200) cycle();
      check("fair", (grants[0] - grants[1] <= 1 && grants[1] - grants[0] <= 1 && grants[0] > 10), 1'b1);

      // Drain everything.
      p_req = 0; p_arr = 100; p_rv = 100; p_rr = 100;
      n = 0;
      while ((bq_id.size() > 0 || r_hold || busy_m || pend[0] || pend[1]) && n < 600) begin
         cycle();
         n++;
      end
      check("drained", n < 600, 1'b1);

      // Move rr to 1, then reset while requester 1 waits on m_arready.
      pend[0] = 1'b1; id_q[0] = 4'hA; pay_q[0] = '0;
      p_rv = 0; n = 0;
      while ((pend[0] || busy_m) && n < 20) begin cycle(); n++; end
      check("t6_rr1", rr_m, 1);
      pend[1] = 1'b1; id_q[1] = 4'h5; pay_q[1] = '1;
      p_arr = 0; n = 0;
      while (!busy_m && n < 20) begin cycle(); n++; end
      cycle();
      check("t6_granted", m_arvalid, 1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6_arvalid", m_arvalid, 1'b0);
      check("t6_arready", s_arready, '0);
      drive_idle();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      pend[0] = 1'b1; id_q[0] = 4'h1; pay_q[0] = '0;
      pend[1] = 1'b1; id_q[1] = 4'h2; pay_q[1] = '0;
      p_arr = 100;
      repeat (6) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
   end

endmodule
`default_nettype wire
